// File: rtl/pht_update_queue_pkg.sv
// Fetch-unit types shared by the PHT update path: branch result, queue entry,
// saturating counter update and bank-conflict test.
package pht_update_queue_pkg;

  localparam int INT_ISSUE_WIDTH        = 2;
  localparam int FETCH_WIDTH            = 2;
  localparam int PHT_INDEX_WIDTH        = 10;
  localparam int PHT_ENTRY_WIDTH        = 2;
  localparam int PHT_ENTRY_MAX          = (1 << PHT_ENTRY_WIDTH) - 1;
  localparam int PHT_UPDATE_QUEUE_DEPTH = 32;
  localparam int PHT_BANK_NUM  = (FETCH_WIDTH > INT_ISSUE_WIDTH) ? FETCH_WIDTH : INT_ISSUE_WIDTH;
  localparam int PHT_BANK_BITS = $clog2(PHT_BANK_NUM);

  typedef logic [PHT_INDEX_WIDTH-1:0] PHT_IndexPath;
  typedef logic [PHT_ENTRY_WIDTH-1:0] PHT_EntryPath;

  // A zero-width bank field yields an all-zero mask, so every read conflicts.
  localparam PHT_IndexPath PHT_BANK_MASK = PHT_IndexPath'((1 << PHT_BANK_BITS) - 1);

  typedef struct packed {
    logic         valid;
    logic         isCondBr;
    logic         execTaken;
    PHT_IndexPath phtIndex;
    PHT_EntryPath phtPrevValue;
  } BranchResult;

  typedef struct packed {
    PHT_IndexPath idx;
    PHT_EntryPath value;
  } PhtUpdateEntry;

  function automatic PHT_EntryPath PhtNextValue(input PHT_EntryPath prev, input logic taken);
    if (taken)
      return (prev == PHT_EntryPath'(PHT_ENTRY_MAX)) ? prev : prev + PHT_EntryPath'(1);
    else
      return (prev == '0) ? prev : prev - PHT_EntryPath'(1);
  endfunction

  function automatic logic IsBankConflict(input PHT_IndexPath a, input PHT_IndexPath b);
    return ((a ^ b) & PHT_BANK_MASK) == '0;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Multi-push, single-pop circular buffer of PHT updates; pushes land in
// consecutive slots from tail in ascending lane order.
module pht_update_fifo
  import pht_update_queue_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int LANES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic          [LANES-1:0]       pushEn,
  input  PhtUpdateEntry [LANES-1:0]       pushData,
  input  logic                            pop,
  output PhtUpdateEntry                   head,
  output logic          [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] PtrPath;

  PhtUpdateEntry mem [DEPTH];
  PtrPath        headPtr, tailPtr;
  PtrPath        slot [LANES];
  logic [PTR_W:0] pushNum;

  always_comb begin
    pushNum = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i] = tailPtr + PtrPath'(pushNum);
      pushNum = pushNum + {{PTR_W{1'b0}}, pushEn[i]};
    end
  end

  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (pushEn[i]) mem[slot[i]] <= pushData[i];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      tailPtr <= tailPtr + PtrPath'(pushNum);
      headPtr <= headPtr + PtrPath'(pop);
      count   <= count + pushNum - (PTR_W+1)'(pop);
    end
  end

  assign head = mem[headPtr];

endmodule

// File: rtl/pht_update_queue.sv
// Queues resolved conditional-branch counter updates and drains them to the
// PHT write port, stalling on fetch read bank conflicts.
// Optional same-cycle bypass when empty: RSD_PHT_QUEUE_BYPASS_EN.
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH    = PHT_UPDATE_QUEUE_DEPTH,
  parameter int ISSUE_LANES    = INT_ISSUE_WIDTH,
  parameter int READ_LANES     = FETCH_WIDTH,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  BranchResult  [ISSUE_LANES-1:0]        brResult,
  input  logic         [READ_LANES-1:0]         rdValid,
  input  PHT_IndexPath [READ_LANES-1:0]         rdIndex,
  output logic                                  phtWE,
  output PHT_IndexPath                          phtWA,
  output PHT_EntryPath                          phtWV,
  output logic                                  empty,
  output logic                                  full,
  output logic         [$clog2(QUEUE_DEPTH):0]  count,
  output logic         [DROP_CNT_WIDTH-1:0]     dropCount
);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int LANE_W = $clog2(ISSUE_LANES + 1);
  typedef logic [CNT_W:0] AvailPath;

  PhtUpdateEntry [ISSUE_LANES-1:0] laneEntry;
  logic          [ISSUE_LANES-1:0] cand, pushEn;
  PhtUpdateEntry                   headEntry, bypassEntry;
  logic                            queueWE, bypassWE, doBypass;
  AvailPath                        avail, accNum;
  logic [LANE_W-1:0]               dropNum;
  logic [DROP_CNT_WIDTH:0]         dropSum;
`ifdef RSD_PHT_QUEUE_BYPASS_EN
  logic                            candSeen;
`endif

  function automatic logic ReadConflict(input PHT_IndexPath idx,
                                        input logic [READ_LANES-1:0] v,
                                        input PHT_IndexPath [READ_LANES-1:0] ri);
    logic hit = 1'b0;
    for (int j = 0; j < READ_LANES; j++)
      if (v[j] && IsBankConflict(idx, ri[j])) hit = 1'b1;
    return hit;
  endfunction

  for (genvar i = 0; i < ISSUE_LANES; i++) begin : g_lane
    assign cand[i]            = brResult[i].valid && brResult[i].isCondBr;
    assign laneEntry[i].idx   = brResult[i].phtIndex;
    assign laneEntry[i].value = PhtNextValue(brResult[i].phtPrevValue, brResult[i].execTaken);
  end

  assign queueWE = rst_n && !empty && !ReadConflict(headEntry.idx, rdValid, rdIndex);

  // Lanes claim free slots lowest-first; whatever does not fit is dropped.
  always_comb begin
    avail       = AvailPath'(QUEUE_DEPTH) - AvailPath'(count) + AvailPath'(queueWE);
    accNum      = '0;
    dropNum     = '0;
    pushEn      = '0;
    bypassWE    = 1'b0;
    bypassEntry = laneEntry[0];
    doBypass    = 1'b0;
`ifdef RSD_PHT_QUEUE_BYPASS_EN
    candSeen    = 1'b0;
`endif
    for (int i = 0; i < ISSUE_LANES; i++) begin
      if (cand[i]) begin
`ifdef RSD_PHT_QUEUE_BYPASS_EN
        doBypass = !candSeen && rst_n && empty &&
                   !ReadConflict(laneEntry[i].idx, rdValid, rdIndex);
        candSeen = 1'b1;
        if (doBypass) begin
          bypassWE    = 1'b1;
          bypassEntry = laneEntry[i];
        end
`endif
        if (!doBypass) begin
          if (accNum < avail) begin
            pushEn[i] = 1'b1;
            accNum    = accNum + AvailPath'(1);
          end else begin
            dropNum   = dropNum + LANE_W'(1);
          end
        end
      end
    end
  end

  pht_update_fifo #(.DEPTH(QUEUE_DEPTH), .LANES(ISSUE_LANES)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .pushEn   (pushEn),
    .pushData (laneEntry),
    .pop      (queueWE),
    .head     (headEntry),
    .count    (count)
  );

  assign dropSum = {1'b0, dropCount} + (DROP_CNT_WIDTH+1)'(dropNum);

  always_ff @(posedge clk) begin
    if (!rst_n)                     dropCount <= '0;
    else if (dropSum[DROP_CNT_WIDTH]) dropCount <= '1;
    else                            dropCount <= dropSum[DROP_CNT_WIDTH-1:0];
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(QUEUE_DEPTH));
  assign phtWE = queueWE || bypassWE;
  assign phtWA = bypassWE ? bypassEntry.idx   : headEntry.idx;
  assign phtWV = bypassWE ? bypassEntry.value : headEntry.value;

endmodule

// File: tb/tb_pht_update_queue.sv
// Directed bench for pht_update_queue (default build, no bypass).
module tb_pht_update_queue;
  import pht_update_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  BranchResult  [INT_ISSUE_WIDTH-1:0] brResult;
  logic         [FETCH_WIDTH-1:0]     rdValid;
  PHT_IndexPath [FETCH_WIDTH-1:0]     rdIndex;
  logic         phtWE;
  PHT_IndexPath phtWA;
  PHT_EntryPath phtWV;
  logic         empty, full;
  logic [$clog2(PHT_UPDATE_QUEUE_DEPTH):0] count;
  logic [15:0]  dropCount;

  int nChecks = 0;
  int nErr    = 0;

  always #5 clk = ~clk;

  pht_update_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .brResult  (brResult),
    .rdValid   (rdValid),
    .rdIndex   (rdIndex),
    .phtWE     (phtWE),
    .phtWA     (phtWA),
    .phtWV     (phtWV),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .dropCount (dropCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setBr(input int lane, input int idx, input int prev, input logic taken);
    brResult[lane] = '{valid: 1'b1, isCondBr: 1'b1, execTaken: taken,
                       phtIndex: PHT_IndexPath'(idx), phtPrevValue: PHT_EntryPath'(prev)};
  endtask

  // Fill pattern: entry k has idx 0x100+k, prev k%4, taken on bit 2 of k.
  task automatic setK(input int lane, input int k);
    setBr(lane, 'h100 + k, k % 4, ((k / 4) % 2) == 1);
  endtask

  function automatic int expVal(input int k);
    int p = k % 4;
    if (((k / 4) % 2) == 1) return (p == 3) ? 3 : p + 1;
    else                    return (p == 0) ? 0 : p - 1;
  endfunction

  initial begin
    brResult = '0;
    rdValid  = '0;
    rdIndex  = '0;
    tick;
    chk("rst_we", phtWE, 0);
    tick;
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      #1;
      chk("idle_empty", empty, 1);
      chk("idle_count", count, 0);
      chk("idle_we", phtWE, 0);
      chk("idle_drop", dropCount, 0);
      tick;
    end

    // Non-conditional results are ignored
    brResult[0] = '{valid: 1'b1, isCondBr: 1'b0, execTaken: 1'b1, phtIndex: 'h33, phtPrevValue: 2'd1};
    tick;
    brResult = '0;
    #1;
    chk("noncond_count", count, 0);
    chk("noncond_we", phtWE, 0);

    // Single update, 1-cycle latency
    setBr(0, 'h12, 1, 1'b1);
    #1;
    chk("same_cycle_we", phtWE, 0);
    tick;
    brResult = '0;
    #1;
    chk("single_we", phtWE, 1);
    chk("single_wa", phtWA, 'h12);
    chk("single_wv", phtWV, 2);
    chk("single_count", count, 1);
    tick;
    #1;
    chk("single_empty", empty, 1);
    chk("single_we_after", phtWE, 0);

    setBr(0, 'h20, 3, 1'b1);
    tick;
    brResult = '0;
    #1;
    chk("sat_up_wa", phtWA, 'h20);
    chk("sat_up_wv", phtWV, 3);
    tick;
    setBr(0, 'h21, 0, 1'b0);
    tick;
    brResult = '0;
    #1;
    chk("sat_dn_wv", phtWV, 0);
    tick;

    // Two lanes in one cycle drain in lane order
    setBr(0, 'h30, 1, 1'b0);
    setBr(1, 'h31, 2, 1'b1);
    tick;
    brResult = '0;
    #1;
    chk("two_count", count, 2);
    chk("two_wa0", phtWA, 'h30);
    chk("two_wv0", phtWV, 0);
    tick;
    #1;
    chk("two_wa1", phtWA, 'h31);
    chk("two_wv1", phtWV, 3);
    tick;
    #1;
    chk("two_empty", empty, 1);

    // Bank conflict stall
    rdValid    = 2'b01;
    rdIndex[0] = 'h08;
    setBr(0, 'h04, 1, 1'b1);
    setBr(1, 'h05, 0, 1'b1);
    tick;
    brResult = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("conf_we", phtWE, 0);
      chk("conf_count", count, 2);
      tick;
    end
    rdValid = '0;
    #1;
    chk("conf_rel_we", phtWE, 1);
    chk("conf_rel_wa", phtWA, 'h04);
    chk("conf_rel_wv", phtWV, 2);
    tick;
    rdValid = 2'b01;  // 0x08 is in the other bank from 0x05
    #1;
    chk("nobank_we", phtWE, 1);
    chk("nobank_wa", phtWA, 'h05);
    chk("nobank_wv", phtWV, 1);
    tick;
    rdValid = '0;
    #1;
    chk("conf_empty", empty, 1);

    // Fill to full with both banks blocked, then overflow by 2
    rdValid    = 2'b11;
    rdIndex[0] = 'h00;
    rdIndex[1] = 'h01;
    for (int c = 0; c < 16; c++) begin
      setK(0, 2 * c);
      setK(1, 2 * c + 1);
      tick;
    end
    brResult = '0;
    #1;
    chk("fill_count", count, 32);
    chk("fill_full", full, 1);
    chk("fill_we", phtWE, 0);
    chk("fill_drop", dropCount, 0);
    setBr(0, 'h200, 1, 1'b1);
    setBr(1, 'h201, 1, 1'b1);
    tick;
    brResult = '0;
    #1;
    chk("ovf_count", count, 32);
    chk("ovf_full", full, 1);
    chk("ovf_drop", dropCount, 2);
    rdValid = '0;
    for (int k = 0; k < 32; k++) begin
      #1;
      chk("drain_we", phtWE, 1);
      chk("drain_wa", phtWA, 'h100 + k);
      chk("drain_wv", phtWV, expVal(k));
      tick;
    end
    #1;
    chk("drain_empty", empty, 1);
    chk("drain_we_end", phtWE, 0);
    chk("drain_drop", dropCount, 2);

    // Full with drain unblocked: push and pop together
    rdValid = 2'b11;
    for (int c = 0; c < 16; c++) begin
      setK(0, 2 * c);
      setK(1, 2 * c + 1);
      tick;
    end
    brResult = '0;
    rdValid  = '0;
    setBr(0, 'h3AA, 2, 1'b0);
    #1;
    chk("fullpp_we", phtWE, 1);
    chk("fullpp_wa", phtWA, 'h100);
    tick;
    brResult = '0;
    setBr(0, 'h3BB, 1, 1'b0);
    setBr(1, 'h3CC, 1, 1'b1);
    #1;
    chk("fullpp_count", count, 32);
    chk("fullpp_full", full, 1);
    chk("fullpp_drop", dropCount, 2);
    chk("fullpp_wa1", phtWA, 'h101);
    tick;
    brResult = '0;
    #1;
    chk("fullpp2_count", count, 32);
    chk("fullpp2_drop", dropCount, 3);
    for (int k = 2; k < 32; k++) begin
      #1;
      chk("fullpp_drain_wa", phtWA, 'h100 + k);
      tick;
    end
    #1;
    chk("fullpp_new_wa", phtWA, 'h3AA);
    chk("fullpp_new_wv", phtWV, 1);
    tick;
    #1;
    chk("fullpp_new2_wa", phtWA, 'h3BB);
    chk("fullpp_new2_wv", phtWV, 0);
    tick;
    #1;
    chk("fullpp_empty", empty, 1);

    // Reset with 5 entries queued discards them
    rdValid = 2'b11;
    setBr(0, 'h50, 1, 1'b1);
    setBr(1, 'h51, 1, 1'b1);
    tick;
    setBr(0, 'h52, 1, 1'b1);
    setBr(1, 'h53, 1, 1'b1);
    tick;
    brResult = '0;
    setBr(0, 'h54, 1, 1'b1);
    tick;
    brResult = '0;
    #1;
    chk("pre_rst_count", count, 5);
    rdValid = '0;
    rst_n   = 1'b0;
    #1;
    chk("rst_gate_we", phtWE, 0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("post_rst_count", count, 0);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_drop", dropCount, 0);
    chk("post_rst_we", phtWE, 0);
    for (int c = 0; c < 5; c++) begin
      tick;
      #1;
      chk("post_rst_idle_we", phtWE, 0);
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

// File: doc/pht_update_queue.md
Name: pht_update_queue

Overview:
- Buffers conditional-branch outcomes from the integer execution lanes and drains them as PHT counter writes, one per cycle.
- Sits downstream of branch resolution and upstream of the PHT write port.
- Stalls a write whenever the head entry's bank collides with an active fetch-side PHT read.
- Computes the saturating 2-bit counter update at enqueue time.

Parameters:
- QUEUE_DEPTH, 32, entry count; power of two, ≥ INT_ISSUE_WIDTH.
- ISSUE_LANES, INT_ISSUE_WIDTH, branch-result input lanes.
- READ_LANES, FETCH_WIDTH, fetch-side PHT read ports checked for conflict.
- DROP_CNT_WIDTH, 16, width of the overflow-drop counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset; one clock, sampled on rising edge of clk.
- brResult  in  ISSUE_LANES x BranchResult  resolved branches from execution lanes.
- rdValid  in  READ_LANES  fetch PHT read active this cycle.
- rdIndex  in  READ_LANES x PHT_IndexPath  fetch PHT read indices.
- phtWE  out  1  PHT write enable.
- phtWA  out  PHT_IndexPath  PHT write index.
- phtWV  out  PHT_EntryPath  new counter value.
- empty  out  1  queue holds no entries.
- full  out  1  count == QUEUE_DEPTH.
- count  out  clog2(QUEUE_DEPTH)+1  occupancy.
- dropCount  out  DROP_CNT_WIDTH  saturating count of discarded updates.

Behaviour:
- Reset (rst_n low at edge): head = tail = count = 0, dropCount = 0. While rst_n is low, phtWE = 0. Reset mid-operation discards all entries; no write is issued in the reset cycle.
- Enqueue candidates: lane i where brResult[i].valid && brResult[i].isCondBr. Accepted in ascending lane order into consecutive slots starting at tail.
- Entry = {phtIndex, newValue}:
  - newValue = execTaken ? min(phtPrevValue+1, PHT_ENTRY_MAX) : max(phtPrevValue-1, 0).
  - Saturate in PHT_ENTRY_WIDTH; no wrap from 3→0 or 0→3.
- Bank conflict: low log2(max(FETCH_WIDTH, INT_ISSUE_WIDTH)) bits of two indices are equal. If that width is 0, any valid read conflicts.
- Drain (combinational from registered state):
  - phtWE = !empty && no lane j with rdValid[j] && conflict(head.idx, rdIndex[j]).
  - phtWA = head.idx; phtWV = head.value.
  - On phtWE the head advances at the next edge.
- Latency: an update enqueued at edge N can be written at earliest in cycle N+1. It is written after all older entries (strict FIFO; no reordering, no coalescing).
- Space: available = QUEUE_DEPTH - count + (phtWE ? 1 : 0). A pop and a push in the same cycle when full is legal.
- Overflow: candidates beyond available, in highest-lane order, are dropped. dropCount += number dropped, saturating at all-ones. Dropped updates are never written.
- Pointers wrap modulo QUEUE_DEPTH.
- count_next = count + accepted - (phtWE ? 1 : 0).
- empty and full are derived from registered count.
- Non-conditional or invalid results never affect state.

Optional Feature:
- Macro RSD_PHT_QUEUE_BYPASS_EN.
- Defined: when empty and the lowest accepted candidate lane has no conflict with any valid read, that update drives phtWE/phtWA/phtWV in the same cycle and is not enqueued. Remaining candidates enqueue normally.
- Undefined: every update passes through the queue, with 1-cycle minimum latency.

Decomposition:
- Shared package (FetchUnitTypes):
  - PhtUpdateEntry struct {PHT_IndexPath idx; PHT_EntryPath value}.
  - PHT_UPDATE_QUEUE_DEPTH constant.
  - Saturating-update function PhtNextValue(prev, taken).
  - The existing IsBankConflict function is reused.
- One natural sub-module: pht_update_fifo, a multi-push, single-pop circular buffer with pointer/count logic. The top level holds the conflict, drop and update arithmetic.

Test Plan:
- Reset then idle → empty = 1, count = 0, phtWE = 0, dropCount = 0 for 10 cycles.
- Single lane-0 result idx = 0x12, prev = 1, taken = 1, no reads → next cycle phtWE = 1, phtWA = 0x12, phtWV = 2; empty again the cycle after. Also check prev = 3 taken → phtWV = 3, and prev = 0 not-taken → phtWV = 0.
- Head idx = 0x04 with rdValid[0] = 1, rdIndex[0] = 0x08 (same bank for 2 banks) for 3 cycles → phtWE = 0 for those cycles. Deassert rdValid → write 0x04 next cycle; FIFO order preserved for a queued 0x05.
- Fill to 32 entries with reads blocking all drains, then 2 more results → count = 32, full = 1, dropCount = 2. Release reads → exactly 32 writes in enqueue order.
- Full queue with drain unblocked, 1 new result in the same cycle → accepted, count stays 32, dropCount unchanged.
- Assert rst_n = 0 with 5 entries queued → next cycle count = 0, phtWE = 0. None of the 5 is ever written.
